// File: rtl/tdc_pkg.sv
// tdc_pkg: shared types and helpers for the TDC averaging sequencer.
//   tdc_seq_state_t : sequencer states
//   TDC_COUNT_W     : default TDC count width
//   tdc_timer_w()   : width of a timer that must reach timeout_cyc
package tdc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    WAIT_LO = 2'd2,
    WAIT_HI = 2'd3
  } tdc_seq_state_t;

  localparam int unsigned TDC_COUNT_W = 8;

  // clog2(timeout_cyc+1), never narrower than one bit
  function automatic int unsigned tdc_timer_w(input int unsigned timeout_cyc);
    int unsigned w;
    w = $clog2(timeout_cyc + 1);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/tdc_minmax_track.sv
// tdc_minmax_track: running minimum/maximum of the samples in one block.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   i_clr     : restart tracking (min = all-ones, max = 0); wins over i_upd
//   i_upd     : fold i_sample into the running min/max
//   i_sample  : sample value
//   o_min     : min including i_sample when i_upd is high (combinational)
//   o_max     : max including i_sample when i_upd is high (combinational)
// The outputs are look-ahead values so the parent can load the final block
// min/max on the same edge that captures the last sample.
module tdc_minmax_track
  import tdc_pkg::*;
#(
  parameter int unsigned W = TDC_COUNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_upd,
  input  logic [W-1:0] i_sample,
  output logic [W-1:0] o_min,
  output logic [W-1:0] o_max
);

  logic [W-1:0] r_min;
  logic [W-1:0] r_max;

  always_comb begin
    o_min = r_min;
    o_max = r_max;
    if (i_upd) begin
      if (i_sample < r_min) o_min = i_sample;
      if (i_sample > r_max) o_max = i_sample;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_min <= '1;
      r_max <= '0;
    end else begin
      r_min <= o_min;
      r_max <= o_max;
    end
  end

endmodule

// File: rtl/tdc_avg_sequencer.sv
// tdc_avg_sequencer: drives TDC start pulses, captures 2^LOG2_N counts and
// presents their truncated average (plus optional min/max) on a valid/ready
// output. Sticky flags report dropped results (overrun) and abandoned
// measurements (timeout).
// Build option: define TDC_MINMAX_EN to include the min/max trackers;
// otherwise min_out/max_out are tied to 0.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   enable             : run continuous measurement blocks while high
//   tdc_count/ready    : TDC result and ready level
//   tdc_start          : one-cycle start pulse to the TDC
//   avg/min/max_out    : block result, qualified by out_valid
//   out_valid/ready    : result handshake
//   clr_flags          : clear overrun/timeout (a same-cycle set wins)
//   overrun, timeout   : sticky status flags
module tdc_avg_sequencer
  import tdc_pkg::*;
#(
  parameter int unsigned COUNT_W     = TDC_COUNT_W,
  parameter int unsigned LOG2_N      = 2,
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [COUNT_W-1:0] tdc_count,
  input  logic               tdc_ready,
  output logic               tdc_start,
  output logic [COUNT_W-1:0] avg_out,
  output logic [COUNT_W-1:0] min_out,
  output logic [COUNT_W-1:0] max_out,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic               clr_flags,
  output logic               overrun,
  output logic               timeout
);

  localparam int unsigned TW = tdc_timer_w(TIMEOUT_CYC);
  localparam int unsigned CW = LOG2_N + 1;
  localparam int unsigned SW = COUNT_W + LOG2_N;
  localparam logic [CW-1:0] N_SAMPLES = CW'(2 ** LOG2_N);
  localparam logic [TW-1:0] TMO_VAL   = TW'(TIMEOUT_CYC);

  tdc_seq_state_t r_state;
  logic [TW-1:0]  r_timer;
  logic [SW-1:0]  r_sum;
  logic [CW-1:0]  r_cnt;

  logic          w_waiting;
  logic          w_tmo;
  logic          w_capture;
  logic          w_complete;
  logic          w_hold;
  logic          w_load;
  logic          w_restart;
  logic [SW-1:0] w_sum_new;
  logic [CW-1:0] w_cnt_inc;

  always_comb begin
    w_waiting  = (r_state == WAIT_LO) || (r_state == WAIT_HI);
    w_tmo      = w_waiting && (r_timer == TMO_VAL);
    // a timeout discards the measurement even if ready arrives that cycle
    w_capture  = (r_state == WAIT_HI) && tdc_ready && !w_tmo;
    w_sum_new  = r_sum + SW'(tdc_count);
    w_cnt_inc  = r_cnt + CW'(1);
    w_complete = w_capture && (w_cnt_inc == N_SAMPLES);
    w_hold     = out_valid && !out_ready;
    w_load     = w_complete && !w_hold;
    // block finished, or partial block abandoned because enable dropped
    w_restart  = w_complete || (w_capture && !enable);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_timer   <= '0;
      r_sum     <= '0;
      r_cnt     <= '0;
      tdc_start <= 1'b0;
      avg_out   <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      tdc_start <= 1'b0;

      // clear first so a same-cycle set below takes precedence
      if (clr_flags) begin
        overrun <= 1'b0;
        timeout <= 1'b0;
      end

      if (w_load) begin
        avg_out   <= w_sum_new[SW-1:LOG2_N];
        out_valid <= 1'b1;
      end else if (w_complete) begin
        overrun <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (w_capture) begin
        r_sum <= w_restart ? '0 : w_sum_new;
        r_cnt <= w_restart ? '0 : w_cnt_inc;
      end

      case (r_state)
        IDLE: begin
          if (enable) begin
            r_state   <= START;
            tdc_start <= 1'b1;
          end
        end
        START: begin
          r_timer <= '0;
          r_state <= WAIT_LO;
        end
        WAIT_LO, WAIT_HI: begin
          if (w_tmo) begin
            timeout <= 1'b1;
            if (enable) begin
              r_state   <= START;
              tdc_start <= 1'b1;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_timer <= r_timer + TW'(1);
            if (r_state == WAIT_LO) begin
              if (!tdc_ready) r_state <= WAIT_HI;
            end else if (tdc_ready) begin
              if (enable) begin
                r_state   <= START;
                tdc_start <= 1'b1;
              end else begin
                r_state <= IDLE;
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef TDC_MINMAX_EN
  logic [COUNT_W-1:0] w_min_nxt;
  logic [COUNT_W-1:0] w_max_nxt;

  tdc_minmax_track #(
    .W(COUNT_W)
  ) u_minmax (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_restart),
    .i_upd    (w_capture),
    .i_sample (tdc_count),
    .o_min    (w_min_nxt),
    .o_max    (w_max_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      min_out <= '0;
      max_out <= '0;
    end else if (w_load) begin
      min_out <= w_min_nxt;
      max_out <= w_max_nxt;
    end
  end
`else
  assign min_out = '0;
  assign max_out = '0;
`endif

endmodule

// File: tb/tb_tdc_avg_sequencer.sv
// tb_tdc_avg_sequencer: directed and randomized checks of tdc_avg_sequencer
// against a behavioural TDC model and block-average reference.
module tb_tdc_avg_sequencer;

  localparam int N = 4;
`ifdef TDC_MINMAX_EN
  localparam bit MM_EN = 1'b1;
`else
  localparam bit MM_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [7:0] tdc_count;
  logic       tdc_ready;
  logic       tdc_start;
  logic [7:0] avg_out;
  logic [7:0] min_out;
  logic [7:0] max_out;
  logic       out_valid;
  logic       out_ready;
  logic       clr_flags;
  logic       overrun;
  logic       timeout;

  int checks = 0;
  int errors = 0;
  int q[$];
  bit tdc_hang = 1'b0;

  always #5 clk = ~clk;

  tdc_avg_sequencer #(
    .COUNT_W     (8),
    .LOG2_N      (2),
    .TIMEOUT_CYC (1023)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .tdc_count (tdc_count),
    .tdc_ready (tdc_ready),
    .tdc_start (tdc_start),
    .avg_out   (avg_out),
    .min_out   (min_out),
    .max_out   (max_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .clr_flags (clr_flags),
    .overrun   (overrun),
    .timeout   (timeout)
  );

  // TDC model: on a start pulse drop ready, then after 2..5 cycles raise it
  // with the next queued count (random when the queue is empty, nothing when hung)
  initial begin
    int d;
    tdc_ready = 1'b0;
    tdc_count = '0;
    forever begin
      @(posedge clk);
      #2;
      if (tdc_start === 1'b1) begin
        tdc_ready = 1'b0;
        d = int'($urandom_range(5, 2));
        repeat (d) begin
          @(posedge clk);
          #2;
        end
        if (q.size() > 0) begin
          tdc_count = 8'(q.pop_front());
          tdc_ready = 1'b1;
        end else if (!tdc_hang) begin
          tdc_count = 8'($urandom_range(255, 0));
          tdc_ready = 1'b1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  function automatic int mm(input int v);
    return MM_EN ? v : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    enable    = 1'b0;
    out_ready = 1'b0;
    clr_flags = 1'b0;
    tdc_hang  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    q.delete();
  endtask

  task automatic wait_valid(input int limit, output int starts, output bit ok);
    starts = 0;
    ok     = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (tdc_start === 1'b1) starts++;
    end
  endtask

  initial begin
    int  starts;
    bit  ok;
    int  cyc;
    int  last;
    int  n;
    int  got;
    int  ea[6];
    int  en[6];
    int  ex[6];

    // ---------------- reset values
    rst = 1'b1; enable = 1'b0; out_ready = 1'b0; clr_flags = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_start",   32'(tdc_start), 0);
    chk("rst_avg",     32'(avg_out),   0);
    chk("rst_min",     32'(min_out),   0);
    chk("rst_max",     32'(max_out),   0);
    chk("rst_valid",   32'(out_valid), 0);
    chk("rst_overrun", 32'(overrun),   0);
    chk("rst_timeout", 32'(timeout),   0);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    // ---------------- basic block 3,5,7,9
    q = '{3, 5, 7, 9};
    enable = 1'b1;
    wait_valid(200, starts, ok);
    chk("t1_valid",      32'(ok),        1);
    chk("t1_starts",     32'(starts),    4);
    chk("t1_next_start", 32'(tdc_start), 1);
    chk("t1_avg",        32'(avg_out),   6);
    chk("t1_min",        32'(min_out),   32'(mm(3)));
    chk("t1_max",        32'(max_out),   32'(mm(9)));
    out_ready = 1'b1;
    enable    = 1'b0;
    @(negedge clk);
    chk("t1_valid_drop", 32'(out_valid), 0);
    do_reset();

    // ---------------- truncation and overrun
    q = '{1, 2, 2, 2, 8, 8, 8, 8};
    enable = 1'b1;
    wait_valid(200, starts, ok);
    chk("t2_valid", 32'(ok),      1);
    chk("t2_avg",   32'(avg_out), 1);
    chk("t2_min",   32'(min_out), 32'(mm(1)));
    chk("t2_max",   32'(max_out), 32'(mm(2)));
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (overrun === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("t2_overrun_set", 32'(ok),        1);
    chk("t2_avg_held",    32'(avg_out),   1);
    chk("t2_valid_held",  32'(out_valid), 1);
    chk("t2_max_held",    32'(max_out),   32'(mm(2)));
    enable = 1'b0;
    repeat (12) @(negedge clk);
    chk("t2_avg_held2", 32'(avg_out), 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("t2_valid_drop",     32'(out_valid), 0);
    chk("t2_overrun_sticky", 32'(overrun),   1);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    chk("t2_overrun_clr", 32'(overrun), 0);
    do_reset();

    // ---------------- timeout keeps the partial block
    q = '{10, 20};
    tdc_hang = 1'b1;
    enable   = 1'b1;
    cyc = 0; last = 0; ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      cyc++;
      if (timeout === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (tdc_start === 1'b1) last = cyc;
    end
    chk("t3_timeout_set", 32'(ok),         1);
    chk("t3_latency",     32'(cyc - last), 1025);
    chk("t3_restart",     32'(tdc_start),  1);
    chk("t3_no_valid",    32'(out_valid),  0);
    q.push_back(30);
    q.push_back(40);
    tdc_hang = 1'b0;
    wait_valid(200, starts, ok);
    chk("t3_valid",          32'(ok),      1);
    chk("t3_avg",            32'(avg_out), 25);
    chk("t3_min",            32'(min_out), 32'(mm(10)));
    chk("t3_max",            32'(max_out), 32'(mm(40)));
    chk("t3_timeout_sticky", 32'(timeout), 1);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    chk("t3_timeout_clr", 32'(timeout), 0);
    do_reset();

    // ---------------- enable dropped after two captures
    q = '{50, 60};
    enable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (q.size() == 0 && tdc_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("t4_second_sample", 32'(ok), 1);
    enable = 1'b0;
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (tdc_start === 1'b1) n++;
    end
    chk("t4_idle_no_start", 32'(n),         0);
    chk("t4_no_valid",      32'(out_valid), 0);
    q = '{4, 4, 4, 4};
    enable = 1'b1;
    wait_valid(200, starts, ok);
    chk("t4_valid", 32'(ok),      1);
    chk("t4_avg",   32'(avg_out), 4);
    chk("t4_min",   32'(min_out), 32'(mm(4)));
    chk("t4_max",   32'(max_out), 32'(mm(4)));

    // ---------------- reset while in WAIT_HI with ready high
    q.push_back(100);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (q.size() == 0 && tdc_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("t5_in_wait_hi", 32'(ok), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_start", 32'(tdc_start), 0);
    chk("t5_avg",   32'(avg_out),   0);
    chk("t5_min",   32'(min_out),   0);
    chk("t5_max",   32'(max_out),   0);
    chk("t5_valid", 32'(out_valid), 0);
    do_reset();

    // ---------------- randomized blocks against the reference
    for (int b = 0; b < 6; b++) begin
      int s, mn, mx, v;
      s = 0; mn = 255; mx = 0;
      for (int k = 0; k < N; k++) begin
        v = int'($urandom_range(255, 0));
        q.push_back(v);
        s += v;
        if (v < mn) mn = v;
        if (v > mx) mx = v;
      end
      ea[b] = s / N;
      en[b] = mm(mn);
      ex[b] = mm(mx);
    end
    enable = 1'b1;
    got = 0;
    for (int i = 0; i < 4000 && got < 6; i++) begin
      bit r;
      @(negedge clk);
      r = ($urandom_range(3, 0) != 0);
      if (out_valid === 1'b1 && r) begin
        chk("rnd_avg", 32'(avg_out), 32'(ea[got]));
        chk("rnd_min", 32'(min_out), 32'(en[got]));
        chk("rnd_max", 32'(max_out), 32'(ex[got]));
        got++;
      end
      out_ready = r;
    end
    chk("rnd_blocks",  32'(got),     6);
    chk("rnd_overrun", 32'(overrun), 0);
    enable = 1'b0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
